mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_arb_pick.sv | 40 ++++
 rtl/mem_arb.sv | 219 +++++++++++++++++++++
 tb/tb_mem_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the I/D-cache to L2 arbiter: FSM state encoding, grant
// identifiers and the grant-to-state mapping used by the top level.
// No ports (package).
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned GNT_ID_W = 2;

  // Arbiter FSM states.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_GNT_I = 3'd1,
    ST_GNT_D = 3'd2,
    ST_GNT_W = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Grant identifiers produced by the picker.
  typedef enum logic [GNT_ID_W-1:0] {
    ID_NONE = 2'd0,
    ID_I    = 2'd1,
    ID_D    = 2'd2,
    ID_W    = 2'd3
  } gnt_e;

  // State entered on the cycle after a grant is issued from IDLE.
  function automatic state_e grant_state(input gnt_e g);
    case (g)
      ID_I:    return ST_GNT_I;
      ID_D:    return ST_GNT_D;
      ID_W:    return ST_GNT_W;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// arb_pick
// Combinational grant picker for mem_arb. A buffered write always wins; a
// d/i read tie goes to D under fixed priority, or to the requester that was
// not granted last when RR is set (mem_arb sets RR from MEM_ARB_RR_EN).
//
// Ports
//   wr_req_i  in   write buffer occupied
//   d_req_i   in   D-cache read request
//   i_req_i   in   I-cache read request
//   last_d_i  in   last read grant went to D (round-robin history)
//   gnt_c     out  selected grant (combinational)
// ----------------------------------------------------------------------------
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic wr_req_i,
  input  logic d_req_i,
  input  logic i_req_i,
  input  logic last_d_i,
  output gnt_e gnt_c
);

  // Priority: write > read tie (fixed D or round-robin) > single read.
  always_comb begin
    gnt_c = ID_NONE;
    if (wr_req_i) begin
      gnt_c = ID_W;
    end else if (d_req_i && i_req_i) begin
      gnt_c = (RR && last_d_i) ? ID_I : ID_D;
    end else if (d_req_i) begin
      gnt_c = ID_D;
    end else if (i_req_i) begin
      gnt_c = ID_I;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// ----------------------------------------------------------------------------
// mem_arb
// Arbitrates I-cache fills, D-cache fills and a one-entry D-cache
// write-through buffer onto a single L2 port, one L2 transaction at a time.
// Optional feature: define MEM_ARB_RR_EN to break d_rd/i_rd ties
// round-robin instead of always favouring D. Writes always go first.
//
// Ports
//   clk        in   clock, rising edge
//   clr_n      in   asynchronous active-low reset
//   i_addr     in   I-cache miss address        i_rd   in  I fill request
//   i_data     out  I fill data                 i_dv   out I fill valid pulse
//   d_addr     in   D-cache address             d_rd   in  D fill request
//   d_wr       in   write-through pulse         d_wdata in write-through line
//   d_data     out  D fill data                 d_dv   out D fill valid pulse
//   d_wr_full  out  write buffer occupied
//   l2_addr    out  L2 address                  l2_rd/l2_wr out strobes
//   l2_wdata   out  L2 write line               l2_rdata in L2 read line
//   l2_dv      in   L2 read data valid / write acknowledge
// ----------------------------------------------------------------------------
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE   = 256,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  output logic [LINE-1:0]   i_data,
  output logic              i_dv,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [LINE-1:0]   d_wdata,
  output logic [LINE-1:0]   d_data,
  output logic              d_dv,
  output logic              d_wr_full,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_rd,
  output logic              l2_wr,
  output logic [LINE-1:0]   l2_wdata,
  input  logic [LINE-1:0]   l2_rdata,
  input  logic              l2_dv
);

`ifdef MEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  state_e              state_q;
  logic [ADDR_W-1:0]   l2_addr_q;
  logic                l2_rd_q;
  logic                l2_wr_q;
  logic [LINE-1:0]     l2_wdata_q;
  logic [LINE-1:0]     i_data_q;
  logic [LINE-1:0]     d_data_q;
  logic                i_dv_q;
  logic                d_dv_q;
  logic                drop_q;
  logic                last_d_q;

  logic                wb_full_q, wb_full_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [LINE-1:0]     wb_data_q, wb_data_d;
  logic                wb_drain_c;

  gnt_e                gnt_c;

  // Grant selection; only consulted while the FSM is in IDLE.
  arb_pick #(
    .RR (RrEn)
  ) u_pick (
    .wr_req_i (wb_full_q),
    .d_req_i  (d_rd),
    .i_req_i  (i_rd),
    .last_d_i (last_d_q),
    .gnt_c    (gnt_c)
  );

  // The buffered write is acknowledged this cycle.
  assign wb_drain_c = (state_q == ST_GNT_W) && l2_dv;

  // Write buffer: accept when empty, or when the current entry drains now.
  always_comb begin
    wb_full_d = wb_full_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (wb_drain_c) begin
      wb_full_d = 1'b0;
    end
    if (d_wr && (!wb_full_q || wb_drain_c)) begin
      wb_full_d = 1'b1;
      wb_addr_d = d_addr;
      wb_data_d = d_wdata;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wb_full_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_full_q <= wb_full_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Arbiter FSM with registered L2 strobes/address and fill responses.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      l2_addr_q  <= '0;
      l2_rd_q    <= 1'b0;
      l2_wr_q    <= 1'b0;
      l2_wdata_q <= '0;
      i_data_q   <= '0;
      d_data_q   <= '0;
      i_dv_q     <= 1'b0;
      d_dv_q     <= 1'b0;
      drop_q     <= 1'b0;
      last_d_q   <= 1'b0;
    end else begin
      // Fill-valid is a single-cycle pulse, set only on entry to RESP.
      i_dv_q <= 1'b0;
      d_dv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          drop_q  <= 1'b0;
          state_q <= grant_state(gnt_c);
          case (gnt_c)
            ID_W: begin
              l2_wr_q    <= 1'b1;
              l2_addr_q  <= wb_addr_q;
              l2_wdata_q <= wb_data_q;
            end
            ID_D: begin
              l2_rd_q   <= 1'b1;
              l2_addr_q <= d_addr;
              last_d_q  <= 1'b1;
            end
            ID_I: begin
              l2_rd_q   <= 1'b1;
              l2_addr_q <= i_addr;
              last_d_q  <= 1'b0;
            end
            default: ;
          endcase
        end

        // A requester that lets go of rd at any point forfeits its dv,
        // but the L2 read still runs to completion.
        ST_GNT_I: begin
          if (!i_rd) begin
            drop_q <= 1'b1;
          end
          if (l2_dv) begin
            l2_rd_q <= 1'b0;
            if (i_rd && !drop_q) begin
              i_data_q <= l2_rdata;
              i_dv_q   <= 1'b1;
              state_q  <= ST_RESP;
            end else begin
              state_q  <= ST_IDLE;
            end
          end
        end

        ST_GNT_D: begin
          if (!d_rd) begin
            drop_q <= 1'b1;
          end
          if (l2_dv) begin
            l2_rd_q <= 1'b0;
            if (d_rd && !drop_q) begin
              d_data_q <= l2_rdata;
              d_dv_q   <= 1'b1;
              state_q  <= ST_RESP;
            end else begin
              state_q  <= ST_IDLE;
            end
          end
        end

        // Buffer release happens in the write-buffer block via wb_drain_c.
        ST_GNT_W: begin
          if (l2_dv) begin
            l2_wr_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign l2_addr   = l2_addr_q;
  assign l2_rd     = l2_rd_q;
  assign l2_wr     = l2_wr_q;
  assign l2_wdata  = l2_wdata_q;
  assign i_data    = i_data_q;
  assign i_dv      = i_dv_q;
  assign d_data    = d_data_q;
  assign d_dv      = d_dv_q;
  assign d_wr_full = wb_full_q;

endmodule

// File: tb/tb_mem_arb.sv
// ----------------------------------------------------------------------------
// tb_mem_arb
// Self-checking bench for mem_arb: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level reference model
// of the arbitration rules, plus an L2 memory model that answers reads.
// ----------------------------------------------------------------------------
module tb_mem_arb;

  localparam int unsigned LINE   = 256;
  localparam int unsigned ADDR_W = 64;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              clr_n;
  logic [ADDR_W-1:0] i_addr, d_addr, l2_addr;
  logic              i_rd, i_dv, d_rd, d_wr, d_dv, d_wr_full, l2_rd, l2_wr, l2_dv;
  logic [LINE-1:0]   i_data, d_data, d_wdata, l2_wdata, l2_rdata;

  mem_arb #(.LINE(LINE), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .i_addr    (i_addr),
    .i_rd      (i_rd),
    .i_data    (i_data),
    .i_dv      (i_dv),
    .d_addr    (d_addr),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_wdata   (d_wdata),
    .d_data    (d_data),
    .d_dv      (d_dv),
    .d_wr_full (d_wr_full),
    .l2_addr   (l2_addr),
    .l2_rd     (l2_rd),
    .l2_wr     (l2_wr),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_dv     (l2_dv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [LINE-1:0] got, input logic [LINE-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef enum {K_W, K_D, K_I} kind_e;

  bit              m_busy, m_resp, m_dropped, m_started;
  kind_e           m_kind;
  logic [63:0]     m_addr;
  logic [LINE-1:0] m_wdata;
  bit              m_wb_full;
  logic [63:0]     m_wb_addr;
  logic [LINE-1:0] m_wb_data;
  bit              m_last_d;
  bit              e_i_dv, e_d_dv;
  logic [LINE-1:0] e_i_data, e_d_data;
  logic [LINE-1:0] mem [logic [63:0]];

  int  wait_cnt    = 0;
  int  force_wait  = -1;
  bit  spurious_en = 1'b0;

  function automatic logic [LINE-1:0] rand_line();
    logic [LINE-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] pick_addr();
    logic [63:0] pool [4];
    pool[0] = 64'h40; pool[1] = 64'h80; pool[2] = 64'h1000; pool[3] = 64'h2000;
    return pool[$urandom_range(0, 3)];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_dropped = 0; m_started = 0;
    m_wb_full = 0; m_last_d = 0; e_i_dv = 0; e_d_dv = 0;
  endtask

  task automatic start_txn(input kind_e k, input logic [63:0] a, input logic [LINE-1:0] w);
    m_busy = 1; m_kind = k; m_addr = a; m_wdata = w; m_dropped = 0; m_started = 1;
    if (k == K_D) m_last_d = 1;
    if (k == K_I) m_last_d = 0;
  endtask

  // Effect of one rising edge given the inputs the DUT just sampled.
  task automatic model_edge();
    bit drain;
    e_i_dv = 0; e_d_dv = 0; m_started = 0;
    drain = m_busy && (m_kind == K_W) && l2_dv;
    if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      if ((m_kind == K_D && !d_rd) || (m_kind == K_I && !i_rd)) m_dropped = 1;
      if (l2_dv) begin
        m_busy = 0;
        if (m_kind == K_W) mem[m_addr] = m_wdata;
        else if (!m_dropped) begin
          m_resp = 1;
          if (m_kind == K_D) begin e_d_dv = 1; e_d_data = l2_rdata; end
          else               begin e_i_dv = 1; e_i_data = l2_rdata; end
        end
      end
    end else begin
      if (m_wb_full)                            start_txn(K_W, m_wb_addr, m_wb_data);
      else if (d_rd && !(i_rd && RR && m_last_d)) start_txn(K_D, d_addr, '0);
      else if (i_rd)                            start_txn(K_I, i_addr, '0);
    end
    if (d_wr && (!m_wb_full || drain)) begin
      m_wb_full = 1; m_wb_addr = d_addr; m_wb_data = d_wdata;
    end else if (drain) begin
      m_wb_full = 0;
    end
  endtask

  task automatic compare_outputs();
    check_eq("l2_rd", l2_rd, m_busy && m_kind != K_W);
    check_eq("l2_wr", l2_wr, m_busy && m_kind == K_W);
    if (m_busy) check_eq("l2_addr", l2_addr, m_addr);
    if (m_busy && m_kind == K_W) check_eq("l2_wdata", l2_wdata, m_wdata);
    check_eq("i_dv", i_dv, e_i_dv);
    check_eq("d_dv", d_dv, e_d_dv);
    if (e_i_dv) check_eq("i_data", i_data, e_i_data);
    if (e_d_dv) check_eq("d_data", d_data, e_d_data);
    check_eq("d_wr_full", d_wr_full, m_wb_full);
  endtask

  // L2 responder: random latency, reads served from the memory model.
  task automatic drive_l2();
    if (m_busy) begin
      if (m_started) wait_cnt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
      if (wait_cnt == 0) begin
        l2_dv    = 1;
        l2_rdata = (m_kind != K_W && mem.exists(m_addr)) ? mem[m_addr] : rand_line();
      end else begin
        l2_dv = 0;
        wait_cnt--;
      end
    end else begin
      l2_dv    = spurious_en && ($urandom_range(0, 15) == 0);
      l2_rdata = rand_line();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_edge();
    compare_outputs();
    drive_l2();
  endtask

  task automatic random_drive(input bit hold);
    bit d_rel, i_rel;
    int unsigned r;
    d_wr  = 0;
    d_rel = e_d_dv && !hold;
    i_rel = e_i_dv && !hold;
    if (d_rel) d_rd = 0;
    if (i_rel) i_rd = 0;
    if (d_rd) begin
      if ($urandom_range(0, 39) == 0) d_rd = 0;
    end else if (!d_rel) begin
      r = $urandom_range(0, 7);
      if (r < 2) begin
        d_rd = 1; d_addr = pick_addr();
      end else if (r < 4 || (m_wb_full && r < 6)) begin
        d_wr = 1; d_addr = pick_addr(); d_wdata = rand_line();
      end
    end
    if (i_rd) begin
      if ($urandom_range(0, 39) == 0) i_rd = 0;
    end else if (!i_rel && $urandom_range(0, 3) == 0) begin
      i_rd = 1; i_addr = pick_addr();
    end
  endtask

  task automatic flush();
    d_rd = 0; i_rd = 0; d_wr = 0;
    for (int c = 0; c < 40 && (m_busy || m_resp || m_wb_full); c++) tick();
    check_eq("flush_idle", {l2_rd, l2_wr, d_wr_full}, 3'b000);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_l2_rd"},     l2_rd, 0);
    check_eq({tag, "_l2_wr"},     l2_wr, 0);
    check_eq({tag, "_l2_addr"},   l2_addr, 0);
    check_eq({tag, "_l2_wdata"},  l2_wdata, 0);
    check_eq({tag, "_dv"},        {i_dv, d_dv}, 0);
    check_eq({tag, "_d_wr_full"}, d_wr_full, 0);
    check_eq({tag, "_i_data"},    i_data, 0);
    check_eq({tag, "_d_data"},    d_data, 0);
  endtask

  // Scenario bookkeeping
  logic [7:0]      order;
  logic [15:0]     gseq;
  logic [63:0]     first_addr;
  logic [1:0]      first_kind;
  logic [LINE-1:0] got_wdata, got_rdata;
  int              ng, dv_cnt;
  bit              prev_rd, seen_rd;

  task automatic watch_wr_rd();
    if (first_kind == 0 && l2_wr) begin first_kind = 2'd1; got_wdata = l2_wdata; end
    else if (first_kind == 0 && l2_rd) first_kind = 2'd2;
    if (d_dv) begin got_rdata = d_data; d_rd = 0; end
  endtask

  initial begin
    clr_n = 0; i_addr = 0; i_rd = 0; d_addr = 0; d_rd = 0; d_wr = 0;
    d_wdata = 0; l2_rdata = 0; l2_dv = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    clr_n = 1;

    // Simultaneous reads: D first, then I.
    d_addr = 64'h2000; d_rd = 1; i_addr = 64'h1000; i_rd = 1;
    order = 0; seen_rd = 0; first_addr = 0;
    for (int c = 0; c < 40 && (d_rd || i_rd); c++) begin
      tick();
      if (l2_rd && !seen_rd) begin seen_rd = 1; first_addr = l2_addr; end
      if (d_dv) begin order = {order[3:0], 4'hD}; d_rd = 0; end
      if (i_dv) begin order = {order[3:0], 4'h1}; i_rd = 0; end
    end
    check_eq("tie_first_addr", first_addr, 64'h2000);
    check_eq("tie_dv_order", order, 8'hD1);

    // Write-through, ignored second write, then read of the same line.
    first_kind = 0; got_wdata = 0; got_rdata = 0;
    d_addr = 64'h40; d_wdata = {32{8'hA5}}; d_wr = 1;
    tick(); watch_wr_rd();
    d_addr = 64'h80; d_wdata = {32{8'h5A}}; d_wr = 1;
    tick(); watch_wr_rd();
    d_wr = 0; d_addr = 64'h40; d_rd = 1;
    for (int c = 0; c < 40 && d_rd; c++) begin tick(); watch_wr_rd(); end
    check_eq("wr_before_rd", first_kind, 2'd1);
    check_eq("wr_full_ignored_wdata", got_wdata, {32{8'hA5}});
    check_eq("raw_read_data", got_rdata, {32{8'hA5}});
    flush();

    // Read dropped after grant: L2 read still completes, no dv.
    force_wait = 4; d_addr = 64'h300; d_rd = 1;
    for (int c = 0; c < 20 && !l2_rd; c++) tick();
    check_eq("drop_granted", l2_rd, 1);
    d_rd = 0; dv_cnt = 0;
    repeat (8) begin tick(); dv_cnt += int'(d_dv); end
    check_eq("drop_no_dv", dv_cnt, 0);
    force_wait = -1;

    // Asynchronous reset in the middle of a D fill.
    force_wait = 8; d_addr = 64'h500; d_rd = 1;
    for (int c = 0; c < 20 && !l2_rd; c++) tick();
    tick();
    clr_n = 0;
    #1;
    check_all_zero("midrst");
    d_rd = 0; i_rd = 0; d_wr = 0; l2_dv = 1; l2_rdata = rand_line();
    @(negedge clk);
    clr_n = 1;
    model_reset();
    force_wait = -1; dv_cnt = 0;
    repeat (6) begin tick(); dv_cnt += int'(d_dv) + int'(i_dv); end
    check_eq("midrst_no_dv", dv_cnt, 0);

    // Both reads held continuously: grant pattern of the first four.
    d_addr = 64'h2000; i_addr = 64'h1000; d_rd = 1; i_rd = 1;
    gseq = 0; ng = 0; prev_rd = 0;
    for (int c = 0; c < 80 && ng < 4; c++) begin
      tick();
      if (l2_rd && !prev_rd) begin
        gseq = {gseq[11:0], (l2_addr == 64'h2000) ? 4'hD : 4'h1};
        ng++;
      end
      prev_rd = l2_rd;
    end
    check_eq("held_grant_seq", gseq, RR ? 16'hD1D1 : 16'hDDDD);
    flush();

    // Random traffic against the model.
    spurious_en = 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      random_drive(cyc >= 600 && cyc < 700);
    end
    spurious_en = 0;
    flush();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
